// File: rtl/epu_defs.sv
// Shared pipeline definitions: NOP payload, control polarities, latch states.
package epu_defs;

  localparam logic [31:0] NOP_PC     = 32'h0000_0000;
  localparam logic [31:0] NOP_INS    = 32'h0000_0013;

  // Active levels of chip reset and stage clear.
  localparam logic        ChipRst    = 1'b1;
  localparam logic        StageClear = 1'b1;

  // Latch state doubles as occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_latch_skid.sv
// Pipeline latch between two stages. SKID=1 gives a two-entry skid buffer
// with a registered up_ready; SKID=0 gives a single pass-through register.
module pipe_latch_skid
  import epu_defs::*;
#(
  parameter int               WIDTH    = 64,
  parameter int               SKID     = 1,
  parameter logic [WIDTH-1:0] NOP_DATA = WIDTH'({NOP_PC, NOP_INS})
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             stall,
  input  logic             clear,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready,
  output logic [1:0]       occupancy
);

  logic             flush;
  logic             go;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] main_q;

  // Clear wins over stall/rdy_in; transfers only happen on a free-running cycle.
  assign flush = (clear == StageClear);
  assign go    = rdy_in & ~stall & ~flush;
  assign push  = up_valid & up_ready & go;
  assign pop   = dn_valid & dn_ready & go;

  // Downstream never sees stale payload while invalid.
  assign dn_data = dn_valid ? main_q : NOP_DATA;

  generate
    if (SKID != 0) begin : g_skid
      state_t           state_q;
      state_t           state_d;
      logic [WIDTH-1:0] skid_q;
      logic [WIDTH-1:0] main_d;
      logic [WIDTH-1:0] skid_d;
      logic             ready_q;

      assign up_ready  = ready_q;
      assign dn_valid  = (state_q != EMPTY);
      assign occupancy = state_q;

      // Next-state and entry update; main always drives dn, skid absorbs one
      // push that lands while downstream is blocked.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = EMPTY;
          main_d  = NOP_DATA;
          skid_d  = NOP_DATA;
        end else begin
          case (state_q)
            EMPTY: begin
              if (push) begin
                state_d = ONE;
                main_d  = up_data;
              end
            end
            ONE: begin
              if (push && !pop) begin
                state_d = FULL;
                skid_d  = up_data;
              end else if (push && pop) begin
                main_d  = up_data;
              end else if (pop) begin
                state_d = EMPTY;
              end
            end
            FULL: begin
              // up_ready is low in FULL, so no push can arrive here.
              if (pop) begin
                state_d = ONE;
                main_d  = skid_q;
                skid_d  = NOP_DATA;
              end
            end
            default: state_d = EMPTY;
          endcase
        end
      end

      // State, entries and the look-ahead ready flop.
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in == ChipRst) begin
          state_q <= EMPTY;
          main_q  <= NOP_DATA;
          skid_q  <= NOP_DATA;
          ready_q <= 1'b1;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
          ready_q <= (state_d != FULL);
        end
      end
    end else begin : g_pass
      logic valid_q;

      assign dn_valid  = valid_q;
      assign up_ready  = ~valid_q | dn_ready;
      assign occupancy = {1'b0, valid_q};

      // Single entry: refill on push, drain on pop-without-push.
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in == ChipRst) begin
          valid_q <= 1'b0;
          main_q  <= NOP_DATA;
        end else if (flush) begin
          valid_q <= 1'b0;
          main_q  <= NOP_DATA;
        end else if (push) begin
          valid_q <= 1'b1;
          main_q  <= up_data;
        end else if (pop) begin
          valid_q <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Directed bench for pipe_latch_skid: SKID=1 and SKID=0 instances with
// queue scoreboards checking order and payload at every pop.
module tb_pipe_latch_skid;

  localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        stall  = 1'b0;
  logic        clear  = 1'b0;

  logic        up_valid = 1'b0;
  logic [63:0] up_data  = '0;
  logic        dn_ready = 1'b0;
  logic        up_ready;
  logic        dn_valid;
  logic [63:0] dn_data;
  logic [1:0]  occupancy;

  logic        s0_up_valid = 1'b0;
  logic [63:0] s0_up_data  = '0;
  logic        s0_dn_ready = 1'b0;
  logic        s0_up_ready;
  logic        s0_dn_valid;
  logic [63:0] s0_dn_data;
  logic [1:0]  s0_occupancy;

  int checks = 0;
  int errors = 0;
  logic [63:0] q1[$];
  logic [63:0] q0[$];

  always #5 clk_in = ~clk_in;

  pipe_latch_skid #(.WIDTH(64), .SKID(1)) u_skid (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall(stall), .clear(clear),
    .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
    .dn_valid(dn_valid), .dn_data(dn_data), .dn_ready(dn_ready), .occupancy(occupancy)
  );

  pipe_latch_skid #(.WIDTH(64), .SKID(0)) u_pass (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall(stall), .clear(clear),
    .up_valid(s0_up_valid), .up_data(s0_up_data), .up_ready(s0_up_ready),
    .dn_valid(s0_dn_valid), .dn_data(s0_dn_data), .dn_ready(s0_dn_ready), .occupancy(s0_occupancy)
  );

  // Scoreboard for the skid instance: handshakes evaluated mid-cycle.
  always @(negedge clk_in) begin
    logic [63:0] e;
    if (!dn_valid) begin
      checks++;
      if (dn_data !== NOP) begin errors++; $display("FAIL sb1_nop: got %h want %h", dn_data, NOP); end
    end
    if (rst_in || clear) q1.delete();
    else if (rdy_in && !stall) begin
      if (dn_valid && dn_ready) begin
        checks++;
        if (q1.size() == 0) begin errors++; $display("FAIL sb1_underflow: got %h, nothing expected", dn_data); end
        else begin
          e = q1.pop_front();
          if (dn_data !== e) begin errors++; $display("FAIL sb1_data: got %h want %h", dn_data, e); end
        end
      end
      if (up_valid && up_ready) q1.push_back(up_data);
    end
  end

  // Scoreboard for the pass-through instance.
  always @(negedge clk_in) begin
    logic [63:0] e;
    if (rst_in || clear) q0.delete();
    else if (rdy_in && !stall) begin
      if (s0_dn_valid && s0_dn_ready) begin
        checks++;
        if (q0.size() == 0) begin errors++; $display("FAIL sb0_underflow: got %h, nothing expected", s0_dn_data); end
        else begin
          e = q0.pop_front();
          if (s0_dn_data !== e) begin errors++; $display("FAIL sb0_data: got %h want %h", s0_dn_data, e); end
        end
      end
      if (s0_up_valid && s0_up_ready) q0.push_back(s0_up_data);
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (occupancy !== 2'd0 || dn_valid !== 1'b0 || dn_data !== NOP || up_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_skid: occ=%0d vld=%b data=%h rdy=%b want 0 0 %h 1", occupancy, dn_valid, dn_data, up_ready, NOP);
    end
    checks++;
    if (s0_occupancy !== 2'd0 || s0_dn_valid !== 1'b0 || s0_dn_data !== NOP || s0_up_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_pass: occ=%0d vld=%b data=%h rdy=%b want 0 0 %h 1", s0_occupancy, s0_dn_valid, s0_dn_data, s0_up_ready, NOP);
    end
    rst_in = 1'b0;
    step();
    checks++;
    if (occupancy !== 2'd0 || up_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: occ=%0d rdy=%b want 0 1", occupancy, up_ready);
    end
  endtask

  task automatic test_stream();
    dn_ready = 1'b1;
    up_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_data = 64'h11 + 64'(i);
      step();
      checks++;
      if (dn_data !== 64'h11 + 64'(i) || occupancy !== 2'd1) begin
        errors++; $display("FAIL stream[%0d]: data=%h occ=%0d want %h 1", i, dn_data, occupancy, 64'h11 + 64'(i));
      end
    end
    up_valid = 1'b0;
    step();
    checks++;
    if (occupancy !== 2'd0 || dn_data !== NOP) begin
      errors++; $display("FAIL stream_drain: occ=%0d data=%h want 0 %h", occupancy, dn_data, NOP);
    end
  endtask

  task automatic test_backpressure();
    dn_ready = 1'b0;
    up_valid = 1'b1;
    up_data  = 64'hA1;
    step();
    checks++;
    if (occupancy !== 2'd1 || up_ready !== 1'b1) begin
      errors++; $display("FAIL bp_one: occ=%0d rdy=%b want 1 1", occupancy, up_ready);
    end
    up_data = 64'hA2;
    step();
    checks++;
    if (occupancy !== 2'd2 || up_ready !== 1'b0 || dn_data !== 64'hA1) begin
      errors++; $display("FAIL bp_full: occ=%0d rdy=%b data=%h want 2 0 a1", occupancy, up_ready, dn_data);
    end
    // Offer a third payload while full; it must be refused, not overwrite skid.
    up_data = 64'hA3;
    step();
    checks++;
    if (occupancy !== 2'd2 || up_ready !== 1'b0 || dn_data !== 64'hA1) begin
      errors++; $display("FAIL bp_hold: occ=%0d rdy=%b data=%h want 2 0 a1", occupancy, up_ready, dn_data);
    end
    up_valid = 1'b0;
    dn_ready = 1'b1;
    step();
    checks++;
    if (occupancy !== 2'd1 || up_ready !== 1'b1 || dn_data !== 64'hA2) begin
      errors++; $display("FAIL bp_pop1: occ=%0d rdy=%b data=%h want 1 1 a2", occupancy, up_ready, dn_data);
    end
    step();
    checks++;
    if (occupancy !== 2'd0) begin
      errors++; $display("FAIL bp_pop2: occ=%0d want 0", occupancy);
    end
  endtask

  task automatic test_flush();
    dn_ready = 1'b0;
    up_valid = 1'b1;
    up_data  = 64'hB1;
    step();
    up_data  = 64'hB2;
    step();
    checks++;
    if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_fill: occ=%0d want 2", occupancy); end
    up_data = 64'hB3;
    clear   = 1'b1;
    step();
    clear    = 1'b0;
    up_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || dn_valid !== 1'b0 || dn_data !== NOP || up_ready !== 1'b1) begin
      errors++; $display("FAIL flush_full: occ=%0d vld=%b data=%h rdy=%b want 0 0 %h 1", occupancy, dn_valid, dn_data, up_ready, NOP);
    end
    dn_ready = 1'b1;
    step();
    step();
    checks++;
    if (dn_valid !== 1'b0) begin errors++; $display("FAIL flush_no_b3: vld=%b data=%h want 0", dn_valid, dn_data); end
    // Clear must act even while stalled and chip not ready.
    dn_ready = 1'b0;
    up_valid = 1'b1;
    up_data  = 64'hB4;
    step();
    up_data = 64'hB5;
    rdy_in  = 1'b0;
    stall   = 1'b1;
    clear   = 1'b1;
    step();
    clear    = 1'b0;
    up_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || dn_valid !== 1'b0) begin
      errors++; $display("FAIL flush_stalled: occ=%0d vld=%b want 0 0", occupancy, dn_valid);
    end
    rdy_in = 1'b1;
    stall  = 1'b0;
  endtask

  task automatic test_stall_ready();
    dn_ready = 1'b0;
    up_valid = 1'b1;
    up_data  = 64'hC1;
    step();
    up_valid = 1'b0;
    dn_ready = 1'b1;
    stall    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dn_data !== 64'hC1 || occupancy !== 2'd1 || up_ready !== 1'b1) begin
        errors++; $display("FAIL stall[%0d]: data=%h occ=%0d rdy=%b want c1 1 1", i, dn_data, occupancy, up_ready);
      end
    end
    stall  = 1'b0;
    rdy_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (dn_data !== 64'hC1 || occupancy !== 2'd1) begin
        errors++; $display("FAIL notrdy[%0d]: data=%h occ=%0d want c1 1", i, dn_data, occupancy);
      end
    end
    rdy_in = 1'b1;
    step();
    checks++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL stall_release: occ=%0d want 0", occupancy); end
  endtask

  task automatic test_async_reset();
    dn_ready = 1'b0;
    up_valid = 1'b1;
    up_data  = 64'hD1;
    step();
    up_data  = 64'hD2;
    step();
    up_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd2) begin errors++; $display("FAIL arst_fill: occ=%0d want 2", occupancy); end
    #2;
    rst_in = 1'b1;
    #1;
    checks++;
    if (occupancy !== 2'd0 || dn_valid !== 1'b0 || dn_data !== NOP || up_ready !== 1'b1) begin
      errors++; $display("FAIL arst_mid: occ=%0d vld=%b data=%h rdy=%b want 0 0 %h 1", occupancy, dn_valid, dn_data, up_ready, NOP);
    end
    step();
    rst_in   = 1'b0;
    dn_ready = 1'b1;
    up_valid = 1'b1;
    up_data  = 64'hE1;
    step();
    up_valid = 1'b0;
    checks++;
    if (dn_data !== 64'hE1 || occupancy !== 2'd1) begin
      errors++; $display("FAIL arst_resume: data=%h occ=%0d want e1 1", dn_data, occupancy);
    end
    step();
  endtask

  task automatic test_pass_through();
    s0_up_valid = 1'b1;
    s0_up_data  = 64'h21;
    s0_dn_ready = 1'b1;
    step();
    checks++;
    if (s0_dn_data !== 64'h21 || s0_occupancy !== 2'd1 || s0_up_ready !== 1'b1) begin
      errors++; $display("FAIL pass_c1: data=%h occ=%0d rdy=%b want 21 1 1", s0_dn_data, s0_occupancy, s0_up_ready);
    end
    s0_up_data  = 64'h22;
    s0_dn_ready = 1'b0;
    #1;
    checks++;
    if (s0_up_ready !== 1'b0) begin errors++; $display("FAIL pass_rdy_low: rdy=%b want 0", s0_up_ready); end
    step();
    checks++;
    if (s0_dn_data !== 64'h21 || s0_occupancy !== 2'd1) begin
      errors++; $display("FAIL pass_c2: data=%h occ=%0d want 21 1", s0_dn_data, s0_occupancy);
    end
    s0_dn_ready = 1'b1;
    #1;
    checks++;
    if (s0_up_ready !== 1'b1) begin errors++; $display("FAIL pass_rdy_high: rdy=%b want 1", s0_up_ready); end
    step();
    checks++;
    if (s0_dn_data !== 64'h22 || s0_occupancy !== 2'd1) begin
      errors++; $display("FAIL pass_c3: data=%h occ=%0d want 22 1", s0_dn_data, s0_occupancy);
    end
    s0_up_data = 64'h23;
    step();
    s0_up_valid = 1'b0;
    checks++;
    if (s0_dn_data !== 64'h23 || s0_occupancy !== 2'd1) begin
      errors++; $display("FAIL pass_c4: data=%h occ=%0d want 23 1", s0_dn_data, s0_occupancy);
    end
    step();
    checks++;
    if (s0_occupancy !== 2'd0 || s0_dn_data !== NOP) begin
      errors++; $display("FAIL pass_drain: occ=%0d data=%h want 0 %h", s0_occupancy, s0_dn_data, NOP);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk_in);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall_ready();
    test_async_reset();
    test_pass_through();
    step();
    checks++;
    if (q1.size() != 0 || q0.size() != 0) begin
      errors++; $display("FAIL sb_leftover: skid=%0d pass=%0d want 0 0", q1.size(), q0.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_latch_skid.md
PIPE_LATCH_SKID -- requirements
Module: pipe_latch_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning payload bits per entry (pc+ins).
REQ-002 SHALL have parameter SKID, default 1, meaning 1 = two-entry skid mode with registered up_ready, 0 = single-entry pass-through register.
REQ-003 SHALL have parameter NOP_DATA, default {NOP_PC, NOP_INS}, meaning the payload driven while dn_valid is low.
REQ-004 SHALL use a single clock and an asynchronous, active-high reset; ports are listed below.
- clk_in  in  1  clock, rising edge
- rst_in  in  1  asynchronous active-high reset
- rdy_in  in  1  chip ready; low freezes all state
- stall  in  1  chip stall; blocks every transfer
- clear  in  1  stage flush
- up_valid  in  1  upstream payload valid
- up_data  in  WIDTH  upstream payload
- up_ready  out  1  block can accept
- dn_valid  out  1  downstream payload valid
- dn_data  out  WIDTH  downstream payload
- dn_ready  in  1  downstream can accept
- occupancy  out  2  entries held (0..2)

Function
REQ-005 SHALL define push = up_valid & up_ready & rdy_in & !stall & !clear, and pop = dn_valid & dn_ready & rdy_in & !stall & !clear.
REQ-006 SHALL deliver accepted payloads downstream in order, with one-cycle latency from push to dn_valid when the block was empty.
REQ-007 SHALL drive dn_data = NOP_DATA whenever dn_valid is 0.
REQ-008 SHALL, in SKID=1, hold state EMPTY/ONE/FULL encoded as occupancy 0/1/2, with a main entry (drives dn) and a skid entry.
REQ-009 SHALL, in SKID=1, drive up_ready directly from a flop, equal to (next state != FULL).
REQ-010 SHALL, in SKID=1, apply these transitions:
- EMPTY + push -> ONE (main = up_data).
- ONE + push & !pop -> FULL (skid = up_data).
- ONE + push & pop -> ONE (main = up_data).
- ONE + pop & !push -> EMPTY.
- FULL + pop -> ONE (main = skid).
- Otherwise hold.
REQ-011 SHALL, in SKID=0, hold one entry with up_ready = !dn_valid | dn_ready combinationally; occupancy ≤ 1; FULL is unreachable.
REQ-012 SHALL, when clear=1, empty both entries at the next edge (occupancy 0, dn_data NOP_DATA), irrespective of stall and rdy_in; the same-cycle upstream payload is dropped.
REQ-013 SHALL, while rdy_in=0 or stall=1 (clear=0), keep all entries, occupancy and up_ready unchanged.
REQ-014 SHALL never overwrite an occupied skid entry nor lose a payload under any dn_ready pattern.

Reset
REQ-015 SHALL, on rst_in=1 asynchronously, force occupancy=0, dn_valid=0, dn_data=NOP_DATA, skid=NOP_DATA, and up_ready=1 (SKID=1).
REQ-016 SHALL discard in-flight payloads on reset mid-operation and resume on the first edge after rst_in deasserts.

Structure
REQ-017 SHALL take NOP_PC, NOP_INS, ChipRst, StageClear and the EMPTY/ONE/FULL state encoding from the shared epu_defs package.
REQ-018 SHALL be a flat module; no sub-module is needed, with SKID selecting the datapath via generate.

Verification
REQ-019 SHALL cover the following directed scenarios:
- Stream: SKID=1, dn_ready=1, push 0x11..0x14 back-to-back -> dn_data 0x11..0x14 on consecutive cycles, occupancy stays 1.
- Backpressure: dn_ready=0, push 0xA1,0xA2 -> occupancy 2, up_ready=0; raise dn_ready -> 0xA1 then 0xA2, up_ready returns 1 one cycle after first pop.
- Flush: FULL with 0xB1,0xB2, clear=1 with up_valid=1 data 0xB3 -> next cycle occupancy 0, dn_data=NOP_DATA, 0xB3 never emitted.
- Stall/ready: ONE with 0xC1, stall=1 for 3 cycles with dn_ready=1, then rdy_in=0 for 2 cycles -> dn_data holds 0xC1, no pop until both released.
- Async reset: rst_in pulse mid-cycle while FULL -> outputs reach reset values before the next edge.
- SKID=0: dn_ready toggling 1,0,1 with continuous push 0x21.. -> up_ready follows dn_ready while full, order preserved, occupancy ≤ 1.
